// File: rtl/coherence_bus_arbiter.sv
// Snoopy MSI bus controller: round-robin grant, one-cycle broadcast, snoop resolve, memory sequencing.
// Latency: bus_valid 1 cycle after grant, done 3+MEM_LATENCY cycles after grant (3 for invalidate); no backpressure, req held until done.
// Optional COH_BUS_STATS_EN adds saturating txn_count/abort_count outputs.
module coherence_bus_arbiter #(
    parameter int NUM_CACHES  = 2,
    parameter int ADDR_WIDTH  = 3,
    parameter int MEM_LATENCY = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CACHES-1:0]            req,
    input  logic [2*NUM_CACHES-1:0]          req_op,
    input  logic [ADDR_WIDTH*NUM_CACHES-1:0] req_addr,
    input  logic [NUM_CACHES-1:0]            snoop_abort,
    output logic [NUM_CACHES-1:0]            grant,
    output logic [NUM_CACHES-1:0]            done,
    output logic                             bus_valid,
    output logic [1:0]                       bus_op,
    output logic [ADDR_WIDTH-1:0]            bus_addr,
    output logic [NUM_CACHES-1:0]            bus_src,
    output logic                             mem_en,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic                             busy
`ifdef COH_BUS_STATS_EN
    ,
    output logic [15:0]                      txn_count,
    output logic [15:0]                      abort_count
`endif
);

    localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BCAST, S_SNOOP, S_MEM, S_WBACK, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IW-1:0]           r_ptr, r_win;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic                    w_any, w_hi_vld;
    logic [IW-1:0]           w_lo, w_hi, w_pick;
    logic [NUM_CACHES-1:0]   w_pick_oh;
    logic [1:0]              w_pick_op;
    logic [ADDR_WIDTH-1:0]   w_pick_addr;
    logic                    w_abort;
    logic [NUM_CACHES-1:0]   w_grant_nxt, w_done_nxt, w_bsrc_nxt;
    logic                    w_bvld_nxt, w_men_nxt, w_mwe_nxt;
    logic [1:0]              w_bop_nxt;
    logic [ADDR_WIDTH-1:0]   w_baddr_nxt, w_maddr_nxt;

    // Round-robin: lowest requester at/after the pointer, else lowest overall (wrap).
    always_comb begin
        w_any    = 1'b0;
        w_hi_vld = 1'b0;
        w_lo     = '0;
        w_hi     = '0;
        for (int j = NUM_CACHES - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_any = 1'b1;
                w_lo  = IW'(j);
            end
            if (req[j] && (IW'(j) >= r_ptr)) begin
                w_hi_vld = 1'b1;
                w_hi     = IW'(j);
            end
        end
        w_pick      = w_hi_vld ? w_hi : w_lo;
        w_pick_oh   = '0;
        w_pick_op   = '0;
        w_pick_addr = '0;
        for (int j = 0; j < NUM_CACHES; j++) begin
            if (w_pick == IW'(j)) begin
                w_pick_oh[j] = 1'b1;
                w_pick_op    = req_op[2*j +: 2];
                w_pick_addr  = req_addr[ADDR_WIDTH*j +: ADDR_WIDTH];
            end
        end
    end

    assign w_abort = |(snoop_abort & ~bus_src);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_bvld_nxt  = 1'b0;
        w_bop_nxt   = bus_op;
        w_baddr_nxt = bus_addr;
        w_bsrc_nxt  = bus_src;
        w_men_nxt   = 1'b0;
        w_mwe_nxt   = 1'b0;
        w_maddr_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_bop_nxt   = '0;
                w_baddr_nxt = '0;
                w_bsrc_nxt  = '0;
                if (w_any) begin
                    w_state_nxt = S_BCAST;
                    w_grant_nxt = w_pick_oh;
                    w_bvld_nxt  = 1'b1;
                    w_bop_nxt   = w_pick_op;
                    w_baddr_nxt = w_pick_addr;
                    w_bsrc_nxt  = w_pick_oh;
                end
            end
            S_BCAST: begin
                w_state_nxt = S_SNOOP;
                w_grant_nxt = bus_src;
            end
            S_SNOOP: begin
                w_grant_nxt = bus_src;
                w_cnt_nxt   = CW'(MEM_LATENCY - 1);
                w_maddr_nxt = bus_addr;
                if (bus_op == 2'b10) begin
                    w_state_nxt = S_DONE;
                    w_grant_nxt = '0;
                    w_done_nxt  = bus_src;
                    w_maddr_nxt = '0;
                end else if (bus_op == 2'b11) begin
                    w_state_nxt = S_MEM;
                    w_men_nxt   = 1'b1;
                    w_mwe_nxt   = 1'b1;
                end else if (w_abort) begin
                    w_state_nxt = S_WBACK;
                    w_men_nxt   = 1'b1;
                    w_mwe_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_MEM;
                    w_men_nxt   = 1'b1;
                end
            end
            S_MEM, S_WBACK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = bus_src;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                    w_grant_nxt = bus_src;
                    w_men_nxt   = 1'b1;
                    w_mwe_nxt   = mem_we;
                    w_maddr_nxt = mem_addr;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            grant     <= '0;
            done      <= '0;
            bus_valid <= 1'b0;
            bus_op    <= '0;
            bus_addr  <= '0;
            bus_src   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            grant     <= w_grant_nxt;
            done      <= w_done_nxt;
            bus_valid <= w_bvld_nxt;
            bus_op    <= w_bop_nxt;
            bus_addr  <= w_baddr_nxt;
            bus_src   <= w_bsrc_nxt;
            mem_en    <= w_men_nxt;
            mem_we    <= w_mwe_nxt;
            mem_addr  <= w_maddr_nxt;
            busy      <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && w_any)
                r_win <= w_pick;
            if (r_state == S_DONE)
                r_ptr <= (r_win == IW'(NUM_CACHES - 1)) ? '0 : r_win + IW'(1);
        end
    end

`ifdef COH_BUS_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_count   <= '0;
            abort_count <= '0;
        end else begin
            if (r_state == S_DONE && txn_count != 16'hFFFF)
                txn_count <= txn_count + 16'd1;
            if (r_state == S_SNOOP && w_state_nxt == S_WBACK && abort_count != 16'hFFFF)
                abort_count <= abort_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: each granted request expands into its expected cycle-by-cycle
// output sequence (broadcast, snoop, memory phase, done), compared every cycle on the falling edge.
module tb_coherence_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 3;
    localparam int L  = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_op;
    logic [AW*N-1:0] req_addr;
    logic [N-1:0]    snoop_abort;
    logic [N-1:0]    grant, done, bus_src;
    logic            bus_valid, mem_en, mem_we, busy;
    logic [1:0]      bus_op;
    logic [AW-1:0]   bus_addr, mem_addr;
`ifdef COH_BUS_STATS_EN
    logic [15:0]     txn_count, abort_count;
`endif

    always #5 clock = ~clock;

    coherence_bus_arbiter #(.NUM_CACHES(N), .ADDR_WIDTH(AW), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
        .snoop_abort(snoop_abort), .grant(grant), .done(done), .bus_valid(bus_valid),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .busy(busy)
`ifdef COH_BUS_STATS_EN
        , .txn_count(txn_count), .abort_count(abort_count)
`endif
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic [N-1:0]  done;
        logic          bvld;
        logic [1:0]    bop;
        logic [AW-1:0] baddr;
        logic [N-1:0]  bsrc;
        logic          men;
        logic          mwe;
        logic [AW-1:0] maddr;
        logic          busy;
        logic          chk_bus;
        logic          snoop;
        logic          idle;
        logic          is_done;
        logic          abt;
    } exp_t;

    exp_t         q[$];
    int           p = 0;
    logic [N-1:0] plan_abort = '0;
    int           total = 0;
    int           bad = 0;
    int           m_txn = 0;
    int           m_abort = 0;

    function automatic exp_t idle_e();
        exp_t e;
        e.grant = '0; e.done = '0; e.bvld = 1'b0; e.bop = '0; e.baddr = '0; e.bsrc = '0;
        e.men = 1'b0; e.mwe = 1'b0; e.maddr = '0; e.busy = 1'b0; e.chk_bus = 1'b0;
        e.snoop = 1'b0; e.idle = 1'b1; e.is_done = 1'b0; e.abt = 1'b0;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check(input exp_t e);
        cmp("grant", 32'(grant), 32'(e.grant));
        cmp("done", 32'(done), 32'(e.done));
        cmp("bus_valid", 32'(bus_valid), 32'(e.bvld));
        cmp("mem_en", 32'(mem_en), 32'(e.men));
        cmp("busy", 32'(busy), 32'(e.busy));
        if (e.chk_bus) begin
            cmp("bus_op", 32'(bus_op), 32'(e.bop));
            cmp("bus_addr", 32'(bus_addr), 32'(e.baddr));
            cmp("bus_src", 32'(bus_src), 32'(e.bsrc));
        end
        if (e.men) begin
            cmp("mem_we", 32'(mem_we), 32'(e.mwe));
            cmp("mem_addr", 32'(mem_addr), 32'(e.maddr));
        end
`ifdef COH_BUS_STATS_EN
        if (e.idle) begin
            cmp("txn_count", 32'(txn_count), 32'(m_txn));
            cmp("abort_count", 32'(abort_count), 32'(m_abort));
        end
`endif
    endtask

    // Expand one granted transaction into the outputs expected on each following cycle.
    task automatic push_txn(input logic [N-1:0] r, input logic [2*N-1:0] ops,
                            input logic [AW*N-1:0] addrs, input logic [N-1:0] ab);
        int            w;
        logic [N-1:0]  tmp, src;
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic          abt;
        exp_t          e;
        w = -1;
        for (int k = 0; k < N; k++) begin
            tmp = r >> ((p + k) % N);
            if (w < 0 && tmp[0]) w = (p + k) % N;
        end
        src = N'(1) << w;
        op  = 2'(ops >> (2 * w));
        a   = AW'(addrs >> (AW * w));
        p   = (w + 1) % N;
        abt = |(ab & ~src);
        plan_abort = ab;
        e = idle_e();
        e.idle = 1'b0; e.busy = 1'b1; e.chk_bus = 1'b1;
        e.grant = src; e.bsrc = src; e.bop = op; e.baddr = a;
        e.bvld = 1'b1;
        q.push_back(e);
        e.bvld = 1'b0; e.snoop = 1'b1; e.abt = (op[1] == 1'b0) && abt;
        q.push_back(e);
        e.snoop = 1'b0; e.abt = 1'b0;
        if (op != 2'b10) begin
            for (int k = 0; k < L; k++) begin
                e.men = 1'b1; e.mwe = (op == 2'b11) || abt; e.maddr = a;
                q.push_back(e);
            end
        end
        e.men = 1'b0; e.mwe = 1'b0; e.maddr = '0;
        e.grant = '0; e.done = src; e.is_done = 1'b1;
        q.push_back(e);
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] r, input logic [2*N-1:0] ops,
                         input logic [AW*N-1:0] addrs, input logic [N-1:0] ab);
        exp_t e;
        @(negedge clock);
        if (q.size() > 0) e = q.pop_front();
        else e = idle_e();
        check(e);
        if (e.is_done) m_txn++;
        if (e.abt) m_abort++;
        reset       = rst;
        req         = r;
        req_op      = ops;
        req_addr    = addrs;
        snoop_abort = e.snoop ? plan_abort : ab;
        if (rst) begin
            q.delete();
            p = 0;
            m_txn = 0;
            m_abort = 0;
        end else if (e.idle && r != '0) begin
            push_txn(r, ops, addrs, ab);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_op = '0; req_addr = '0; snoop_abort = '0;
        repeat (2) cycle(1'b1, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        // cache 0 read miss at 101, no snooper owns the line
        cycle(1'b0, 2'b01, 4'b0000, 6'b000_101, 2'b00);
        repeat (7) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        // both caches requesting continuously from reset: strict alternation
        cycle(1'b1, 2'b00, 4'b0000, 6'b000_000, 2'b00);
        repeat (24) cycle(1'b0, 2'b11, 4'b0100, 6'b110_001, 2'b00);
        repeat (8) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        // cache 1 write miss at 011: owner abort, then its own (ignored) abort
        cycle(1'b0, 2'b10, 4'b0100, 6'b011_000, 2'b01);
        repeat (8) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);
        cycle(1'b0, 2'b10, 4'b0100, 6'b011_000, 2'b10);
        repeat (8) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        // cache 0 invalidate at 010
        cycle(1'b0, 2'b01, 4'b0010, 6'b000_010, 2'b00);
        repeat (5) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        // reset lands during the memory phase; afterwards cache 0 wins first
        cycle(1'b0, 2'b01, 4'b0000, 6'b000_111, 2'b00);
        repeat (2) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);
        cycle(1'b1, 2'b00, 4'b0000, 6'b000_000, 2'b00);
        repeat (10) cycle(1'b0, 2'b11, 4'b1100, 6'b100_110, 2'b11);
        repeat (8) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        repeat (600) begin
            cycle(($urandom_range(0, 59) == 0), N'($urandom), (2*N)'($urandom),
                  (AW*N)'($urandom), N'($urandom));
        end
        repeat (10) cycle(1'b0, 2'b00, 4'b0000, 6'b000_000, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
